// File: rtl/q2_div_recover.sv
// ============================================================================
// Module   : q2_div_recover
// Purpose  : Radix-2 restoring divider. Recovers num2 and a remainder from a
//            product of the form 7*num1*num2 and a known num1.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module q2_div_recover #(
    parameter int N  = 20,
    parameter int PW = 2*N+3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [PW-1:0] product,
    input  logic [N-1:0]  num1,
    output logic          busy,
    output logic          done,
    output logic [N-1:0]  num2,
    output logic [N+2:0]  rem,
    output logic          exact,
    output logic          ovf,
    output logic          err
);

    localparam int CW = $clog2(PW);

    localparam logic [1:0] C_IDLE = 2'd0;
    localparam logic [1:0] C_CALC = 2'd1;
    localparam logic [1:0] C_FIN  = 2'd2;

    logic [1:0]    state_q, state_d;
    logic [CW-1:0] cnt_q,   cnt_d;
    logic [N+2:0]  div_q,   div_d;
    logic [PW-1:0] dvd_q,   dvd_d;
    logic [PW-1:0] quo_q,   quo_d;
    logic [N+2:0]  part_q,  part_d;
    logic [N-1:0]  num2_q,  num2_d;
    logic [N+2:0]  rem_q,   rem_d;
    logic          exact_q, exact_d;
    logic          ovf_q,   ovf_d;
    logic          err_q,   err_d;

    logic          w_accept;
    logic          w_zero;
    logic [N+2:0]  w_div7;
    logic [N+3:0]  w_shift;
    logic [N+3:0]  w_sub;
    logic          w_ge;
    logic [N+2:0]  w_rnext;
    logic [PW-1:0] w_qnext;

    assign w_accept = (state_q == C_IDLE) && start;
    assign w_zero   = (num1 == '0);
    assign w_div7   = {num1, 3'b000} - {3'b000, num1};

    // One restoring step: shift in the next dividend bit, subtract if it fits.
    assign w_shift = {part_q, dvd_q[cnt_q]};
    assign w_sub   = w_shift - {1'b0, div_q};
    assign w_ge    = (w_shift >= {1'b0, div_q});
    assign w_rnext = w_ge ? w_sub[N+2:0] : w_shift[N+2:0];
    assign w_qnext = {quo_q[PW-2:0], w_ge};

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= C_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            C_IDLE: if (start) state_d = w_zero ? C_FIN : C_CALC;
            C_CALC: if (cnt_q == '0) state_d = C_FIN;
            C_FIN:  state_d = C_IDLE;
            default: state_d = C_IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        busy = (state_q != C_IDLE);
        done = (state_q == C_FIN);
    end

    // Datapath next values; results are captured on the edge that enters FIN.
    always_comb begin
        cnt_d   = cnt_q;
        div_d   = div_q;
        dvd_d   = dvd_q;
        quo_d   = quo_q;
        part_d  = part_q;
        num2_d  = num2_q;
        rem_d   = rem_q;
        exact_d = exact_q;
        ovf_d   = ovf_q;
        err_d   = err_q;
        if (w_accept) begin
            div_d   = w_div7;
            dvd_d   = product;
            quo_d   = '0;
            part_d  = '0;
            cnt_d   = CW'(PW-1);
            num2_d  = '0;
            rem_d   = '0;
            exact_d = 1'b0;
            ovf_d   = 1'b0;
            err_d   = 1'b0;
            if (w_zero) begin
                err_d  = 1'b1;
                num2_d = '1;
            end
        end else if (state_q == C_CALC) begin
            part_d = w_rnext;
            quo_d  = w_qnext;
            if (cnt_q == '0) begin
                num2_d  = w_qnext[N-1:0];
                rem_d   = w_rnext;
                ovf_d   = |w_qnext[PW-1:N];
                exact_d = (w_rnext == '0);
            end else begin
                cnt_d = cnt_q - CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q   <= '0;
            div_q   <= '0;
            dvd_q   <= '0;
            quo_q   <= '0;
            part_q  <= '0;
            num2_q  <= '0;
            rem_q   <= '0;
            exact_q <= 1'b0;
            ovf_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            div_q   <= div_d;
            dvd_q   <= dvd_d;
            quo_q   <= quo_d;
            part_q  <= part_d;
            num2_q  <= num2_d;
            rem_q   <= rem_d;
            exact_q <= exact_d;
            ovf_q   <= ovf_d;
            err_q   <= err_d;
        end
    end

    assign num2  = num2_q;
    assign rem   = rem_q;
    assign exact = exact_q;
    assign ovf   = ovf_q;
    assign err   = err_q;

endmodule

`default_nettype wire

// File: tb/tb_q2_div_recover.sv
// ============================================================================
// Module   : tb_q2_div_recover
// Purpose  : Self-checking bench for q2_div_recover against an arithmetic model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_q2_div_recover;

    localparam int N  = 20;
    localparam int PW = 2*N+3;

    logic          clk;
    logic          rst;
    logic          start;
    logic [PW-1:0] product;
    logic [N-1:0]  num1;
    logic          busy;
    logic          done;
    logic [N-1:0]  num2;
    logic [N+2:0]  rem;
    logic          exact;
    logic          ovf;
    logic          err;

    int n_checks = 0;
    int n_pass   = 0;

    q2_div_recover #(.N(N), .PW(PW)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .product (product),
        .num1    (num1),
        .busy    (busy),
        .done    (done),
        .num2    (num2),
        .rem     (rem),
        .exact   (exact),
        .ovf     (ovf),
        .err     (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    task automatic chk_idle_zero(input string tag);
        chk({tag, ".busy"},  64'(busy),  64'd0);
        chk({tag, ".done"},  64'(done),  64'd0);
        chk({tag, ".num2"},  64'(num2),  64'd0);
        chk({tag, ".rem"},   64'(rem),   64'd0);
        chk({tag, ".flags"}, {61'd0, exact, ovf, err}, 64'd0);
    endtask

    // Reference: plain integer division of the product by 7*num1.
    task automatic run_op(input string tag, input logic [N-1:0] n1, input logic [PW-1:0] p,
                          input bit pulse_mid);
        logic [63:0] d, q, r, e_num2, e_rem;
        bit          e_ovf, e_exact, e_err;
        int          e_lat, lat, busy_cyc, extra_done;
        if (n1 == '0) begin
            e_err = 1'b1; e_num2 = 64'hFFFFF; e_rem = 0; e_ovf = 1'b0; e_exact = 1'b0; e_lat = 1;
        end else begin
            d = 64'd7 * 64'(n1);
            q = 64'(p) / d;
            r = 64'(p) % d;
            e_err = 1'b0; e_num2 = q % (64'd1 << N); e_rem = r;
            e_ovf = (q >= (64'd1 << N)); e_exact = (r == 0); e_lat = PW + 1;
        end
        @(negedge clk);
        num1 = n1; product = p; start = 1'b1;
        @(posedge clk);
        lat = 0; busy_cyc = 0;
        while (lat < 4*PW) begin
            @(negedge clk);
            start = (pulse_mid && lat == 10);
            num1 = ~n1; product = ~p;
            lat++;
            if (busy) busy_cyc++;
            if (done) break;
        end
        start = 1'b0;
        chk({tag, ".latency"}, 64'(lat), 64'(e_lat));
        chk({tag, ".busy_cycles"}, 64'(busy_cyc), 64'(e_lat));
        chk({tag, ".num2"}, 64'(num2), e_num2);
        chk({tag, ".rem"}, 64'(rem), e_rem);
        chk({tag, ".flags"}, {61'd0, exact, ovf, err}, {61'd0, e_exact, e_ovf, e_err});
        @(negedge clk);
        chk({tag, ".done_pulse"}, {62'd0, busy, done}, 64'd0);
        if (pulse_mid) begin
            extra_done = 0;
            repeat (PW + 5) begin
                @(negedge clk);
                if (done) extra_done++;
            end
            chk({tag, ".no_second_done"}, 64'(extra_done), 64'd0);
        end
        repeat (3) @(negedge clk);
        chk({tag, ".hold_num2"}, 64'(num2), e_num2);
    endtask

    initial begin
        logic [63:0] rp, rn2;
        logic [N-1:0] rn1;
        int dn, cyc, t_done[$];

        rst = 1'b1; start = 1'b0; product = '0; num1 = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_idle_zero("reset");
        rst = 1'b0;

        run_op("nom_1x2", 20'd1, 43'd14, 1'b0);
        run_op("nom_2x3", 20'd2, 43'd42, 1'b0);
        run_op("nom_6x8", 20'd6, 43'd336, 1'b0);
        run_op("nonexact", 20'd6, 43'd337, 1'b0);
        rp = 64'd7 * 64'hFFFFF * 64'hFFFFF;
        run_op("max", 20'hFFFFF, rp[PW-1:0], 1'b0);
        rp = 64'd7 << N;
        run_op("overflow", 20'd1, rp[PW-1:0], 1'b0);
        run_op("div_zero", 20'd0, 43'd5, 1'b0);
        run_op("mid_start", 20'd3, 43'd99, 1'b1);

        // Reset mid-CALC aborts without a done pulse.
        @(negedge clk);
        num1 = 20'd5; product = 43'd700; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (19) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk_idle_zero("abort");
        dn = 0;
        repeat (PW + 5) begin
            @(negedge clk);
            if (done) dn++;
        end
        chk("abort.no_done", 64'(dn), 64'd0);
        run_op("after_abort", 20'd5, 43'd700, 1'b0);

        // Reset and start together: reset wins.
        @(negedge clk);
        rst = 1'b1; start = 1'b1; num1 = 20'd4; product = 43'd56;
        @(negedge clk);
        rst = 1'b0; start = 1'b0;
        chk("rst_start.busy", 64'(busy), 64'd0);
        @(negedge clk);
        chk("rst_start.busy2", 64'(busy), 64'd0);

        // Start held high: one operation every PW+2 cycles.
        num1 = 20'd9; product = 43'd7 * 43'd9 * 43'd1000;
        start = 1'b1;
        cyc = 0;
        while (cyc < 5*(PW+2) && t_done.size() < 3) begin
            @(negedge clk);
            cyc++;
            if (done) t_done.push_back(cyc);
        end
        start = 1'b0;
        chk("b2b.count", 64'(t_done.size()), 64'd3);
        if (t_done.size() == 3) begin
            chk("b2b.first", 64'(t_done[0]), 64'(PW + 1));
            chk("b2b.gap1", 64'(t_done[1] - t_done[0]), 64'(PW + 2));
            chk("b2b.gap2", 64'(t_done[2] - t_done[1]), 64'(PW + 2));
            chk("b2b.num2", 64'(num2), 64'd1000);
        end
        cyc = 0;
        while (busy && cyc < 2*PW) begin
            @(negedge clk);
            cyc++;
        end
        chk("b2b.drain", 64'(busy), 64'd0);

        // Randomised decodes.
        for (int i = 0; i < 24; i++) begin
            rn1 = ($urandom_range(0, 7) == 0) ? '0 : N'($urandom);
            case ($urandom_range(0, 2))
                0: begin
                    rn2 = 64'($urandom) % (64'd1 << N);
                    rp  = 64'd7 * 64'(rn1) * rn2;
                end
                1: begin
                    rn2 = 64'($urandom) % (64'd1 << N);
                    rp  = 64'd7 * 64'(rn1) * rn2 + 64'($urandom_range(0, 6));
                end
                default: rp = {32'($urandom), 32'($urandom)};
            endcase
            run_op($sformatf("rand%0d", i), rn1, rp[PW-1:0], 1'b0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
